// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared datapath widths and ALU operand-A select encodings
package riscv_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_REG_ADDR_WIDTH = 5;
  localparam int DEFAULT_NUM_FWD        = 2;
  localparam int DEFAULT_CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    ALU_A_REG     = 2'b00,
    ALU_A_PC      = 2'b01,
    ALU_A_ZERO    = 2'b10,
    ALU_A_DEFAULT = 2'b11
  } alu_src_a_e;

  // Only the register encodings may pick up a forwarded result.
  function automatic logic is_reg_path(input logic [1:0] sel);
    return (sel == ALU_A_REG) || (sel == ALU_A_DEFAULT);
  endfunction

endpackage

// File: rtl/alu_operand_a_stage_if.sv
// rtl/alu_operand_a_stage_if.sv - request, forwarding and result bundle of the operand-A stage
interface alu_operand_a_stage_if
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
  parameter int NUM_FWD        = DEFAULT_NUM_FWD,
  parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
);

  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_WIDTH-1:0]         reg_data;
  logic [REG_ADDR_WIDTH-1:0]     rs1_addr;
  logic [DATA_WIDTH-1:0]         pc_current;
  logic [1:0]                    alu_src_a;
  logic [NUM_FWD-1:0]            fwd_reg_write;
  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_rd_addr;
  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_data;
  logic                          flush;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         alu_input_a;
  logic [NUM_FWD-1:0]            fwd_hit;
  logic [CNT_WIDTH-1:0]          fwd_count;

  modport master (
    output in_valid, reg_data, rs1_addr, pc_current, alu_src_a,
           fwd_reg_write, fwd_rd_addr, fwd_data, flush, out_ready,
    input  in_ready, out_valid, alu_input_a, fwd_hit, fwd_count
  );

  modport slave (
    input  in_valid, reg_data, rs1_addr, pc_current, alu_src_a,
           fwd_reg_write, fwd_rd_addr, fwd_data, flush, out_ready,
    output in_ready, out_valid, alu_input_a, fwd_hit, fwd_count
  );

endinterface

// File: rtl/alu_operand_a_stage_fwd_select.sv
// rtl/alu_operand_a_stage_fwd_select.sv - priority match of rs1 against the forwarding sources
module fwd_select
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
  parameter int NUM_FWD        = DEFAULT_NUM_FWD
) (
  input  logic [REG_ADDR_WIDTH-1:0]         rs1_addr,
  input  logic [NUM_FWD-1:0]                fwd_reg_write,
  input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_rd_addr,
  input  logic [NUM_FWD*DATA_WIDTH-1:0]     fwd_data,
  output logic [NUM_FWD-1:0]                hit,
  output logic                              any_hit,
  output logic [DATA_WIDTH-1:0]             data
);

  // Walk from the oldest source down so the youngest match overwrites the rest.
  always_comb begin
    hit     = '0;
    any_hit = 1'b0;
    data    = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_reg_write[i] &&
          (fwd_rd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == rs1_addr) &&
          (rs1_addr != '0)) begin
        hit     = '0;
        hit[i]  = 1'b1;
        any_hit = 1'b1;
        data    = fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/alu_operand_a_stage.sv
// rtl/alu_operand_a_stage.sv - registered operand-A select with forwarding, handshake and hit counter
module alu_operand_a_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
  parameter int NUM_FWD        = DEFAULT_NUM_FWD,
  parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  alu_operand_a_stage_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [NUM_FWD-1:0]    match_hit;
  logic                  match_any;
  logic [DATA_WIDTH-1:0] match_data;

  logic [DATA_WIDTH-1:0] sel_value;
  logic [NUM_FWD-1:0]    sel_hit;
  logic                  sel_any;

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NUM_FWD-1:0]    hit_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic                  ready;
  logic                  accept;

  fwd_select #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .NUM_FWD        (NUM_FWD)
  ) u_fwd_select (
    .rs1_addr      (bus.rs1_addr),
    .fwd_reg_write (bus.fwd_reg_write),
    .fwd_rd_addr   (bus.fwd_rd_addr),
    .fwd_data      (bus.fwd_data),
    .hit           (match_hit),
    .any_hit       (match_any),
    .data          (match_data)
  );

  always_comb begin
    sel_value = bus.reg_data;
    sel_hit   = '0;
    sel_any   = 1'b0;
    if (bus.alu_src_a == ALU_A_PC) begin
      sel_value = bus.pc_current;
    end else if (bus.alu_src_a == ALU_A_ZERO) begin
      sel_value = '0;
    end else if (is_reg_path(bus.alu_src_a) && match_any) begin
      sel_value = match_data;
      sel_hit   = match_hit;
      sel_any   = 1'b1;
    end
  end

  // Flush always frees the slot so a killed request never stalls upstream.
  assign ready  = bus.flush | ~valid_q | bus.out_ready;
  assign accept = bus.in_valid & ready & ~bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      hit_q   <= '0;
      cnt_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      hit_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= sel_value;
      hit_q   <= sel_hit;
      if (sel_any && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = valid_q;
  assign bus.alu_input_a = data_q;
  assign bus.fwd_hit     = hit_q;
  assign bus.fwd_count   = cnt_q;

endmodule

// File: tb/tb_alu_operand_a_stage.sv
// tb/tb_alu_operand_a_stage.sv - randomized and directed bench for alu_operand_a_stage
module tb_alu_operand_a_stage;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  alu_operand_a_stage_if bus ();
  alu_operand_a_stage_if #(.CNT_WIDTH(2)) bus2 ();

  alu_operand_a_stage dut (.clk(clk), .reset(reset), .bus(bus));
  alu_operand_a_stage #(.CNT_WIDTH(2)) dut_sat (.clk(clk), .reset(reset), .bus(bus2));

  assign bus2.in_valid      = bus.in_valid;
  assign bus2.reg_data      = bus.reg_data;
  assign bus2.rs1_addr      = bus.rs1_addr;
  assign bus2.pc_current    = bus.pc_current;
  assign bus2.alu_src_a     = bus.alu_src_a;
  assign bus2.fwd_reg_write = bus.fwd_reg_write;
  assign bus2.fwd_rd_addr   = bus.fwd_rd_addr;
  assign bus2.fwd_data      = bus.fwd_data;
  assign bus2.flush         = bus.flush;
  assign bus2.out_ready     = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the operand-A stage as a one-entry buffer plus an event tally.
  bit        m_valid;
  bit [31:0] m_a;
  bit [1:0]  m_hit;
  int        m_cnt;

  function automatic void model_select(output bit [31:0] val, output bit [1:0] hit);
    bit [4:0]  rd [2];
    bit [31:0] fd [2];
    rd[0] = bus.fwd_rd_addr[4:0];
    rd[1] = bus.fwd_rd_addr[9:5];
    fd[0] = bus.fwd_data[31:0];
    fd[1] = bus.fwd_data[63:32];
    hit = 2'b00;
    if (bus.alu_src_a == 2'b01) val = bus.pc_current;
    else if (bus.alu_src_a == 2'b10) val = 32'h0;
    else begin
      val = bus.reg_data;
      for (int i = 0; i < 2; i++) begin
        if (bus.fwd_reg_write[i] && rd[i] == bus.rs1_addr && bus.rs1_addr != 0) begin
          val = fd[i];
          hit = 2'(1 << i);
          break;
        end
      end
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 0; m_a = 0; m_hit = 0; m_cnt = 0;
    end else begin
      bit        rdy;
      bit [31:0] v;
      bit [1:0]  h;
      rdy = bus.flush || !m_valid || bus.out_ready;
      if (bus.flush) begin
        m_valid = 0;
        m_hit   = 0;
      end else if (bus.in_valid && rdy) begin
        model_select(v, h);
        m_valid = 1;
        m_a     = v;
        m_hit   = h;
        if (h != 0) m_cnt++;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("sat_out_valid", 64'(bus2.out_valid), 64'(m_valid));
      check("in_ready", 64'(bus.in_ready), 64'(bus.flush || !m_valid || bus.out_ready));
      check("fwd_count", 64'(bus.fwd_count), 64'(m_cnt & 32'hffff));
      check("sat_fwd_count", 64'(bus2.fwd_count), 64'((m_cnt > 3) ? 3 : m_cnt));
      if (m_valid) begin
        check("alu_input_a", 64'(bus.alu_input_a), 64'(m_a));
        check("fwd_hit", 64'(bus.fwd_hit), 64'(m_hit));
        check("sat_alu_input_a", 64'(bus2.alu_input_a), 64'(m_a));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input bit [1:0] we, input bit [4:0] rd0, input bit [4:0] rd1,
                         input bit [31:0] d0, input bit [31:0] d1);
    bus.fwd_reg_write = we;
    bus.fwd_rd_addr   = {rd1, rd0};
    bus.fwd_data      = {d1, d0};
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.in_valid = 0; bus.reg_data = 0; bus.rs1_addr = 0; bus.pc_current = 0;
    bus.alu_src_a = 0; bus.flush = 0; bus.out_ready = 0;
    set_fwd(2'b00, 0, 0, 0, 0);
    #12;
    check("reset_valid", 64'(bus.out_valid), 64'h0);
    check("reset_a", 64'(bus.alu_input_a), 64'h0);
    check("reset_cnt", 64'(bus.fwd_count), 64'h0);
    reset = 1'b0;
    cyc();

    // Path selection without forwarding
    bus.in_valid = 1; bus.out_ready = 1;
    bus.reg_data = 32'hAAAAAAAA; bus.pc_current = 32'hBBBBBBBB; bus.rs1_addr = 5'd7;
    bus.alu_src_a = 2'b00; cyc(); check("path_reg", 64'(bus.alu_input_a), 64'hAAAAAAAA);
    bus.alu_src_a = 2'b01; cyc(); check("path_pc", 64'(bus.alu_input_a), 64'hBBBBBBBB);
    bus.alu_src_a = 2'b10; cyc(); check("path_zero", 64'(bus.alu_input_a), 64'h0);
    bus.alu_src_a = 2'b11; cyc(); check("path_dflt", 64'(bus.alu_input_a), 64'hAAAAAAAA);

    // Forward priority
    bus.rs1_addr = 5'd5; bus.alu_src_a = 2'b00;
    set_fwd(2'b11, 5, 5, 32'h11111111, 32'h22222222);
    cyc();
    check("prio_a", 64'(bus.alu_input_a), 64'h11111111);
    check("prio_hit", 64'(bus.fwd_hit), 64'h1);
    check("prio_cnt", 64'(bus.fwd_count), 64'h1);

    // x0 and PC never forward
    bus.rs1_addr = 5'd0; set_fwd(2'b11, 0, 0, 32'h33333333, 32'h44444444);
    cyc();
    check("x0_a", 64'(bus.alu_input_a), 64'hAAAAAAAA);
    check("x0_hit", 64'(bus.fwd_hit), 64'h0);
    bus.rs1_addr = 5'd5; bus.alu_src_a = 2'b01; set_fwd(2'b01, 5, 0, 32'h33333333, 0);
    cyc();
    check("pcfwd_a", 64'(bus.alu_input_a), 64'hBBBBBBBB);
    check("pcfwd_hit", 64'(bus.fwd_hit), 64'h0);
    check("pcfwd_cnt", 64'(bus.fwd_count), 64'h1);

    // Backpressure
    bus.alu_src_a = 2'b00; set_fwd(2'b00, 0, 0, 0, 0);
    bus.reg_data = 32'hCAFEBABE;
    cyc();
    check("bp_first", 64'(bus.alu_input_a), 64'hCAFEBABE);
    bus.out_ready = 0; bus.reg_data = 32'h12345678;
    repeat (3) begin
      #1;
      check("bp_in_ready", 64'(bus.in_ready), 64'h0);
      cyc();
      check("bp_hold", 64'(bus.alu_input_a), 64'hCAFEBABE);
      bus.reg_data = $urandom;
      bus.pc_current = $urandom;
      set_fwd(2'b11, 5, 5, $urandom, $urandom);
    end
    set_fwd(2'b00, 0, 0, 0, 0);
    bus.out_ready = 1; bus.reg_data = 32'hDEADBEEF;
    #1;
    check("bp_release_ready", 64'(bus.in_ready), 64'h1);
    cyc();
    check("bp_next", 64'(bus.alu_input_a), 64'hDEADBEEF);

    // Flush with a held entry and a forwarded request pending
    bus.out_ready = 0; bus.flush = 1;
    set_fwd(2'b01, 5, 0, 32'h99999999, 0);
    #1;
    check("flush_in_ready", 64'(bus.in_ready), 64'h1);
    cyc();
    bus.flush = 0;
    check("flush_valid", 64'(bus.out_valid), 64'h0);
    check("flush_hit", 64'(bus.fwd_hit), 64'h0);
    check("flush_cnt", 64'(bus.fwd_count), 64'h1);

    // Saturation: five more forwarded accepts
    bus.out_ready = 1;
    repeat (5) cyc();
    check("sat_main_cnt", 64'(bus.fwd_count), 64'h6);
    check("sat_cnt2", 64'(bus2.fwd_count), 64'h3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.flush      = ($urandom_range(0, 15) == 0);
      bus.alu_src_a  = 2'($urandom_range(0, 3));
      bus.rs1_addr   = 5'($urandom_range(0, 3));
      bus.reg_data   = $urandom;
      bus.pc_current = $urandom;
      set_fwd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              $urandom, $urandom);
      cyc();
    end

    // Asynchronous reset while stalled
    bus.flush = 0; bus.in_valid = 1; bus.out_ready = 0;
    bus.alu_src_a = 2'b00; bus.rs1_addr = 5'd5; set_fwd(2'b01, 5, 0, 32'h55555555, 0);
    cyc();
    cyc();
    #2;
    reset = 1'b1;
    #1;
    check("areset_valid", 64'(bus.out_valid), 64'h0);
    check("areset_a", 64'(bus.alu_input_a), 64'h0);
    check("areset_hit", 64'(bus.fwd_hit), 64'h0);
    check("areset_cnt", 64'(bus.fwd_count), 64'h0);
    check("areset_sat_cnt", 64'(bus2.fwd_count), 64'h0);
    #2;
    reset = 1'b0;
    bus.in_valid = 0;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_operand_a_stage.md
# alu_operand_a_stage

Parametrised, registered successor to the combinational ALU operand-A selector in the RISC-V datapath. Picks operand A from register data, current PC or zero; when the register path is selected, it substitutes a matching forwarded result from later pipeline stages. The chosen value is captured in an ID/EX-style pipeline register with a valid/ready handshake, flush support and a saturating forwarding-event counter. Sits between the register file read and the ALU.

## Interface
- DATA_WIDTH, 32: operand width.
- REG_ADDR_WIDTH, 5: register index width.
- NUM_FWD, 2: number of forwarding sources. Index 0 is the youngest (EX/MEM), index 1 is MEM/WB.
- CNT_WIDTH, 16: width of the forwarding-event counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream operand request valid.
- in_ready  out  1  stage can accept a request.
- reg_data  in  DATA_WIDTH  register-file rs1 value.
- rs1_addr  in  REG_ADDR_WIDTH  rs1 index.
- pc_current  in  DATA_WIDTH  PC of the instruction.
- alu_src_a  in  2  select: 00 register, 01 PC, 10 zero, 11 register (default).
- fwd_reg_write  in  NUM_FWD  source i writes a register.
- fwd_rd_addr  in  NUM_FWD*REG_ADDR_WIDTH  destination of source i (slice i).
- fwd_data  in  NUM_FWD*DATA_WIDTH  result of source i (slice i).
- flush  in  1  kill the held entry and any incoming request.
- out_valid  out  1  alu_input_a valid.
- out_ready  in  1  downstream consumes.
- alu_input_a  out  DATA_WIDTH  registered operand A.
- fwd_hit  out  NUM_FWD  one-hot (or zero) record of the source used for the held entry.
- fwd_count  out  CNT_WIDTH  number of accepted requests that used forwarding; saturates.

## Operation
- Register path is active when alu_src_a is 00 or 11. PC path (01) and zero path (10) never forward.
- Source i matches when all of the following hold: fwd_reg_write[i]=1, fwd_rd_addr slice i equals rs1_addr, and rs1_addr≠0.
- If several sources match, the lowest index wins. With no match, reg_data is used.
- Selected value = forwarded data, reg_data, pc_current or 0, according to the rules above. Evaluated combinationally from the current-cycle inputs.
- in_ready = flush OR NOT out_valid OR out_ready.
- Accept = in_valid AND in_ready AND NOT flush.
- On accept:
  - alu_input_a and fwd_hit capture the selected value and one-hot match.
  - out_valid is set to 1.
  - fwd_count increments if any fwd_hit bit is set, saturating at all-ones.
- On out_valid AND out_ready with no accept: out_valid is cleared. Data is held (don't-care).
- When out_valid=1 and out_ready=0: alu_input_a, fwd_hit and out_valid stay stable.
- Flush:
  - Next cycle out_valid=0 and fwd_hit=0.
  - A simultaneous in_valid is consumed (in_ready=1) but discarded; fwd_count is unchanged.
  - Flush has priority over accept and over the hold.
- fwd_count is not cleared by flush, only by reset.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 request per cycle while out_ready=1.
- Reset (asynchronous assertion, takes effect immediately): out_valid=0, alu_input_a=0, fwd_hit=0, fwd_count=0.
- Reset mid-stall drops the held entry.
- in_ready depends combinationally on out_ready and flush. No other combinational in-to-out path exists.
- Forwarding inputs are sampled only in the accept cycle. Later changes do not alter the held value.

## Structure
- Shared riscv_pkg holds:
  - ALU_A_REG=2'b00, ALU_A_PC=2'b01, ALU_A_ZERO=2'b10, ALU_A_DEFAULT=2'b11.
  - The default widths.
- Sub-module fwd_select (combinational): NUM_FWD-way priority match on rs1_addr, producing hit vector, any_hit and forwarded data.
- The top level adds the source mux, the pipeline register, the handshake and the counter.

## Test plan
- Path selection, no forwarding: reg_data=AAAAAAAA, pc_current=BBBBBBBB; drive alu_src_a=00/01/10/11 with out_ready=1 → alu_input_a is AAAAAAAA/BBBBBBBB/00000000/AAAAAAAA, each one cycle after accept.
- Forward priority: rs1_addr=5, both sources write rd=5 with data 11111111 (index 0) and 22222222 (index 1), alu_src_a=00 → alu_input_a=11111111, fwd_hit=01, fwd_count=1.
- No forwarding for x0 or PC: rs1_addr=0 with a matching source gives reg_data; alu_src_a=01 with a matching rd gives pc_current. fwd_hit=0 and fwd_count unchanged in both cases.
- Backpressure: accept CAFEBABE, hold out_ready=0 for 3 cycles while changing the inputs and offering in_valid → output stays CAFEBABE, in_ready=0; raise out_ready → next request accepted the same cycle.
- Flush: flush with out_valid=1 and in_valid=1 → next cycle out_valid=0, in_ready was 1, fwd_count unchanged.
- Reset and saturation: with CNT_WIDTH=2, perform 5 forwarded accepts → fwd_count=3. Assert reset asynchronously mid-cycle → all outputs 0 immediately.
